// File: rtl/ysyx_22041461_exu_lsu_reg.sv
// ysyx_22041461_exu_lsu_reg: EX->MEM skid-buffered stage with precomputed store mask/data and misalign flag.
// Define YSYX_22041461_EXLSU_PERF_EN to add stall and skid-write counters.
module ysyx_22041461_exu_lsu_reg #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_dest,
  input  logic            in_alu_flag,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_rd_wen,
  input  logic [3:0]      in_mem_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_addr,
  output logic            out_flag,
  output logic [RD_W-1:0] out_rd,
  output logic            out_rd_wen,
  output logic [3:0]      out_mem_ctrl,
  output logic [XLEN-1:0] out_wdata,
  output logic [7:0]      out_wmask,
  output logic            out_misalign
`ifdef YSYX_22041461_EXLSU_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_skid_cnt
`endif
);
  localparam int EW = 3 * XLEN + RD_W + 15;
  logic [EW-1:0] m_ent, s_ent, in_ent;
  logic m_valid, s_valid, acc, drn, mis, ls;
  logic [2:0] a;
  logic [7:0] base, mask;
  assign a = in_alu_dest[2:0];
  assign ls = in_mem_ctrl[2] | in_mem_ctrl[3];
  assign base = in_mem_ctrl[1:0] == 2'd0 ? 8'h01 : in_mem_ctrl[1:0] == 2'd1 ? 8'h03 :
                in_mem_ctrl[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  assign mis = in_mem_ctrl[1:0] == 2'd1 ? a[0] : in_mem_ctrl[1:0] == 2'd2 ? |a[1:0] :
               in_mem_ctrl[1:0] == 2'd3 ? |a : 1'b0;
  assign mask = base << a;
  assign in_ent = {in_pc, in_alu_dest, in_alu_flag, in_rd, in_rd_wen, in_mem_ctrl,
                   in_rs2_data << {a, 3'b000}, (ls & ~mis) ? mask : 8'h00, ls & mis};
  assign {out_pc, out_addr, out_flag, out_rd, out_rd_wen, out_mem_ctrl,
          out_wdata, out_wmask, out_misalign} = m_ent;
  assign in_ready = ~s_valid;
  assign out_valid = m_valid;
  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ent <= '0;
      s_ent <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (acc) begin
        m_ent <= in_ent;
        m_valid <= 1'b1;
      end
    end else if (drn) begin
      if (s_valid) begin
        m_ent <= s_ent;
        s_valid <= 1'b0;
      end else if (acc) m_ent <= in_ent;
      else m_valid <= 1'b0;
    end else if (acc) begin
      s_ent <= in_ent;
      s_valid <= 1'b1;
    end
  end
`ifdef YSYX_22041461_EXLSU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_skid_cnt <= '0;
    end else begin
      if (out_valid & ~out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!flush & m_valid & ~drn & acc) perf_skid_cnt <= perf_skid_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/ysyx_22041461_exu_lsu_reg.md
Name: ysyx_22041461_exu_lsu_reg

Overview:
- EX→MEM pipeline stage. Registers the ALU result plus destination/memory control.
- Pre-computes the store byte mask, lane-shifted write data and the misalignment flag for the load/store unit.
- Two-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush from the branch/trap redirect.
- Sits directly downstream of the ALU; its output feeds the LSU.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  EX holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  64  instruction PC.
- in_alu_dest  in  64  ALU result; memory address for load/store.
- in_alu_flag  in  1  ALU flag, passed through unchanged.
- in_rs2_data  in  64  store data.
- in_rd  in  RD_W  destination register index.
- in_rd_wen  in  1  register write enable.
- in_mem_ctrl  in  4  [1:0] size (00=B, 01=H, 10=W, 11=D); [2]=load; [3]=store; [2] and [3] are never both set.
- out_valid  out  1  entry available to LSU.
- out_ready  in  1  LSU accepts.
- out_pc, out_addr  out  64 each  registered copies of in_pc, in_alu_dest.
- out_flag  out  1  registered in_alu_flag.
- out_rd, out_rd_wen, out_mem_ctrl  out  RD_W/1/4  registered copies.
- out_wdata  out  64  store data shifted left by 8*addr[2:0].
- out_wmask  out  8  byte-lane mask.
- out_misalign  out  1  load/store address not aligned to its size.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit.
  - in_ready = !S.valid; combinational from a register, with no path from out_ready.
- Accept: acc = in_valid & in_ready. Drain: drn = out_valid & out_ready.
- Derived fields are computed at capture and stored.
  - mask: B=8'h01, H=8'h03, W=8'h0F, D=8'hFF, shifted left by addr[2:0] and truncated to 8 bits.
  - Misalignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - If misaligned, or if neither load nor store is set, out_wmask=0.
  - out_misalign = (load|store) & misaligned.
- Next state when M.valid=0: on acc, load M.
- Next state when M.valid=1, drn=1, S.valid=0:
  - On acc, M ← input; otherwise M.valid ← 0.
- Next state when M.valid=1, drn=1, S.valid=1: M ← S; S.valid ← 0. acc is impossible because in_ready=0.
- Next state when M.valid=1, drn=0: on acc, S ← input.
- Latency: an input accepted at edge N is visible on outputs after edge N (1 cycle) when M is empty or draining. Ordering is strictly FIFO.
- Throughput: one per cycle while out_ready=1.
- flush=1: M.valid ← 0 and S.valid ← 0 at that edge. A simultaneous acc is dropped; a simultaneous drn completes normally for the LSU. The next cycle has in_ready=1 and out_valid=0.
- Reset (rst_n=0 at an edge, dominates flush): both valid bits 0; all out_* data registers 0; in_ready=1 from the first post-reset cycle.
  - Reset mid-transfer discards all content.
- Outputs of an entry stay stable while out_valid=1 and out_ready=0.
- Data registers may be left unchanged when not loading; valid bits alone gate meaning.

Optional Feature:
- Macro YSYX_22041461_EXLSU_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0]: increments each cycle with out_valid=1 and out_ready=0, wraps at 2^32, reset to 0, unaffected by flush.
  - Adds output perf_skid_cnt [31:0]: increments on each write of S.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 → out_valid=0, in_ready=1, out_addr=0, out_wmask=0.
- Streaming: out_ready=1 and in_valid=1 for 4 beats, addr=0x1000,0x1008,0x1010,0x1018, store D → each appears 1 cycle later in order, out_wmask=8'hFF, out_misalign=0.
- Backpressure: out_ready=0 while 3 inputs are offered → first two accepted, third held with in_ready=0. Raise out_ready → outputs in order; the third is accepted after S empties; nothing is lost.
- Store lanes: store H, addr=0x2006, rs2=0x1234 → out_wmask=8'hC0, out_wdata=0x1234_0000_0000_0000, misalign=0.
  - Store W, addr=0x2006 → out_misalign=1, out_wmask=0.
- Flush with M and S full plus in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed and offered entries never appear.
- Reset asserted while S is full and out_ready=0 → after the edge, out_valid=0 and in_ready=1.
